// File: rtl/lb_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : lb_responder_if
// Brief   : Local-bus handshake bundle between a bus master and lb_responder.
// Revision: 1.0 - initial release
// ============================================================================
interface lb_responder_if;
   logic [23:0] lb_addr;
   logic        lb_write;
   logic        lb_read;
   logic [31:0] lb_wdata;
   logic [31:0] lb_rdata;

   modport master (
      output lb_addr,
      output lb_write,
      output lb_read,
      output lb_wdata,
      input  lb_rdata
   );

   modport slave (
      input  lb_addr,
      input  lb_write,
      input  lb_read,
      input  lb_wdata,
      output lb_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lb_responder.sv
`default_nettype none
// ============================================================================
// Module  : lb_responder
// Brief   : Local-bus register block: 8 RW registers, ID word, 64-bit cycle
//           counter with high snapshot, and a readback FIFO that is built only
//           when LB_RESPONDER_FIFO_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module lb_responder #(
   parameter logic [23:0] BASE          = 24'h000000,
   parameter int          READ_PIPE_LEN = 3,
   parameter logic [31:0] ID_WORD       = 32'h4C425231,
   parameter int          FIFO_AW       = 3
) (
   input  wire logic         clk,
   input  wire logic         rst,
   lb_responder_if.slave     lb,
   output logic [255:0]      reg_out,
   input  wire logic [31:0]  fifo_din,
   input  wire logic         fifo_push,
   output logic              fifo_full
);

   // ------------------------------------------------------------------------
   // Decode and read-start detection
   // ------------------------------------------------------------------------
   logic        w_hit;
   logic [3:0]  w_off;
   logic        w_wr_hit;
   logic        w_read_start;
   logic        r_prev_read;
   logic [23:0] r_prev_addr;

   assign w_hit        = (lb.lb_addr[23:4] == BASE[23:4]);
   assign w_off        = lb.lb_addr[3:0];
   assign w_wr_hit     = lb.lb_write && w_hit;
   // A held read only restarts when the address moves underneath it.
   assign w_read_start = lb.lb_read && (!r_prev_read || (lb.lb_addr != r_prev_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_read <= 1'b0;
         r_prev_addr <= '0;
      end else begin
         r_prev_read <= lb.lb_read;
         r_prev_addr <= lb.lb_addr;
      end
   end

   // ------------------------------------------------------------------------
   // RW registers
   // ------------------------------------------------------------------------
   logic [31:0] r_regs [0:7];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_hit && !w_off[3]) begin
         r_regs[w_off[2:0]] <= lb.lb_wdata;
      end
   end

   generate
      for (genvar n = 0; n < 8; n++) begin : g_reg_out
         assign reg_out[32*n +: 32] = r_regs[n];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Cycle counter and high-word snapshot
   // ------------------------------------------------------------------------
   logic [63:0] r_count;
   logic [31:0] r_snap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_snap  <= '0;
      end else begin
         r_count <= r_count + 64'd1;
         if (w_read_start && w_hit && (w_off == 4'h9)) begin
            r_snap <= r_count[63:32];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Readback FIFO
   // ------------------------------------------------------------------------
   logic [31:0] w_status;
   logic [31:0] w_head;

`ifdef LB_RESPONDER_FIFO_EN
   localparam int                 c_DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   c_FULL_OCC = (FIFO_AW+1)'(c_DEPTH);
   localparam logic [FIFO_AW:0]   c_OCC_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] c_PTR_ONE  = FIFO_AW'(1);

   logic [31:0]        r_mem [0:c_DEPTH-1];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_occ;
   logic               r_ovf;
   logic               r_unf;

   logic w_empty;
   logic w_full;
   logic w_clear;
   logic w_pop_req;
   logic w_pop;
   logic w_push;
   logic w_ovf_set;
   logic w_unf_set;

   assign w_empty   = (r_occ == '0);
   assign w_full    = (r_occ == c_FULL_OCC);
   assign w_clear   = w_wr_hit && (w_off == 4'hB) && lb.lb_wdata[0];
   assign w_pop_req = w_read_start && w_hit && (w_off == 4'hC);
   assign w_pop     = w_pop_req && !w_empty;
   // A real pop frees a slot in the same cycle, so a full FIFO still accepts.
   assign w_push    = fifo_push && !w_clear && (!w_full || w_pop);
   assign w_ovf_set = fifo_push && w_full && !w_pop;
   assign w_unf_set = w_pop_req && w_empty;

   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_occ <= r_occ + c_OCC_ONE;
         end else if (w_pop && !w_push) begin
            r_occ <= r_occ - c_OCC_ONE;
         end
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
         if (w_unf_set) begin
            r_unf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= fifo_din;
      end
   end

   always_comb begin
      w_status              = '0;
      w_status[FIFO_AW:0]   = r_occ;
      w_status[16]          = r_ovf;
      w_status[17]          = r_unf;
      w_status[31]          = w_empty;
   end

   assign w_head    = w_empty ? 32'd0 : r_mem[r_rptr];
   assign fifo_full = w_full;
`else
   logic w_unused_fifo;

   assign w_unused_fifo = &{1'b0, fifo_din, fifo_push};
   assign w_status      = '0;
   assign w_head        = '0;
   assign fifo_full     = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Read select and latency pipeline
   // ------------------------------------------------------------------------
   logic [31:0] w_rsel;

   always_comb begin
      w_rsel = '0;
      if (w_hit) begin
         if (!w_off[3]) begin
            w_rsel = r_regs[w_off[2:0]];
         end else begin
            case (w_off[2:0])
               3'd0:    w_rsel = ID_WORD;
               3'd1:    w_rsel = r_count[31:0];
               3'd2:    w_rsel = r_snap;
               3'd3:    w_rsel = w_status;
               3'd4:    w_rsel = w_head;
               default: w_rsel = '0;
            endcase
         end
      end
   end

   logic [31:0]              r_pipe_data [0:READ_PIPE_LEN-1];
   logic [READ_PIPE_LEN-1:0] r_pipe_vld;
   logic [31:0]              r_rdata_hold;
   logic [31:0]              w_rdata;

   // The last stage overrides the held value only in the cycle a result lands.
   assign w_rdata     = r_pipe_vld[READ_PIPE_LEN-1] ? r_pipe_data[READ_PIPE_LEN-1]
                                                     : r_rdata_hold;
   assign lb.lb_rdata = w_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_vld   <= '0;
         r_rdata_hold <= '0;
         for (int k = 0; k < READ_PIPE_LEN; k++) begin
            r_pipe_data[k] <= '0;
         end
      end else begin
         r_pipe_vld[0]  <= w_read_start;
         r_pipe_data[0] <= w_rsel;
         for (int k = 1; k < READ_PIPE_LEN; k++) begin
            r_pipe_vld[k]  <= r_pipe_vld[k-1];
            r_pipe_data[k] <= r_pipe_data[k-1];
         end
         r_rdata_hold <= w_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lb_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_lb_responder
// Brief   : Self-checking bench for lb_responder with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lb_responder;

   localparam logic [23:0] BASE  = 24'h00AB30;
   localparam int          N     = 3;
   localparam int          DEPTH = 8;
   localparam logic [31:0] ID    = 32'h4C425231;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] reg_out;
   logic [31:0]  fifo_din;
   logic         fifo_push;
   logic         fifo_full;

   int n_tests = 0;
   int n_fail  = 0;

   lb_responder_if bus ();

   lb_responder #(
      .BASE          (BASE),
      .READ_PIPE_LEN (N),
      .ID_WORD       (ID),
      .FIFO_AW       (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .lb        (bus),
      .reg_out   (reg_out),
      .fifo_din  (fifo_din),
      .fifo_push (fifo_push),
      .fifo_full (fifo_full)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_regs [0:7];
   logic [63:0] m_cyc;
   logic [31:0] q [$];
   bit          m_ovf;
   bit          m_unf;

   always @(posedge clk) begin
      if (rst) m_cyc <= 64'd0;
      else     m_cyc <= m_cyc + 64'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s     = 32'(q.size());
      s[16] = m_ovf;
      s[17] = m_unf;
      s[31] = (q.size() == 0);
      return s;
   endfunction

   task automatic do_access(input logic [23:0] a, input logic wr, input logic [31:0] wd,
                            output logic [31:0] d);
      bus.lb_addr  = a;
      bus.lb_write = wr;
      bus.lb_wdata = wd;
      bus.lb_read  = 1'b1;
      tick();
      bus.lb_write = 1'b0;
      bus.lb_read  = 1'b0;
      repeat (N-1) tick();
      d = bus.lb_rdata;
   endtask

   task automatic do_read(input logic [23:0] a, output logic [31:0] d);
      do_access(a, 1'b0, 32'd0, d);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [31:0] wd);
      bus.lb_addr  = a;
      bus.lb_wdata = wd;
      bus.lb_write = 1'b1;
      tick();
      bus.lb_write = 1'b0;
   endtask

   // Pop is evaluated against the pre-cycle contents, then the push.
   task automatic fifo_op(input bit do_push, input bit do_pop, input logic [31:0] din);
      logic [31:0] exp;
      logic [31:0] rd;
      exp = 32'd0;
      if (do_pop) begin
         if (q.size() == 0) m_unf = 1'b1;
         else               exp = q.pop_front();
      end
      if (do_push) begin
         if (q.size() < DEPTH) q.push_back(din);
         else                  m_ovf = 1'b1;
      end
      bus.lb_addr = BASE + 24'hC;
      bus.lb_read = do_pop;
      fifo_push   = do_push;
      fifo_din    = din;
      tick();
      bus.lb_read = 1'b0;
      fifo_push   = 1'b0;
      if (do_pop) begin
         repeat (N-1) tick();
         rd = bus.lb_rdata;
         check("fifo_pop", rd, exp);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp;
      logic [31:0] d;
      logic [2:0]  r;
      int          op;

      rst          = 1'b1;
      bus.lb_addr  = '0;
      bus.lb_write = 1'b0;
      bus.lb_read  = 1'b0;
      bus.lb_wdata = '0;
      fifo_din     = '0;
      fifo_push    = 1'b0;
      model_reset();
      repeat (3) tick();
      check("rst_rdata", bus.lb_rdata, 32'd0);
      for (int i = 0; i < 8; i++) check("rst_reg_out", reg_out[32*i +: 32], 32'd0);
      check("rst_full", {31'd0, fifo_full}, 32'd0);
      rst = 1'b0;

      // Write then read with exact latency
      do_write(BASE + 24'h3, 32'hDEADBEEF);
      m_regs[3] = 32'hDEADBEEF;
      bus.lb_addr = BASE + 24'h3;
      bus.lb_read = 1'b1;
      tick();
      bus.lb_read = 1'b0;
      check("lat_early1", bus.lb_rdata, 32'd0);
      tick();
      check("lat_early2", bus.lb_rdata, 32'd0);
      tick();
      check("lat_exact", bus.lb_rdata, 32'hDEADBEEF);
      check("reg_out3", reg_out[127:96], 32'hDEADBEEF);

      // ID, hold, then miss
      do_read(BASE + 24'h8, rd);
      check("id", rd, ID);
      repeat (2) tick();
      check("hold", bus.lb_rdata, ID);
      do_read(BASE + 24'h10, rd);
      check("miss", rd, 32'd0);

      // Read-only and reserved offsets ignore writes
      do_write(BASE + 24'h8, 32'h12345678);
      do_read(BASE + 24'h8, rd);
      check("id_ro", rd, ID);
      do_write(BASE + 24'hD, 32'hFFFFFFFF);
      do_read(BASE + 24'hD, rd);
      check("reserved", rd, 32'd0);

      // Same-cycle read and write returns the old value
      do_write(BASE + 24'h5, 32'h0000A5A5);
      m_regs[5] = 32'h0000A5A5;
      do_access(BASE + 24'h5, 1'b1, 32'h5A5A0000, rd);
      check("rw_old", rd, m_regs[5]);
      m_regs[5] = 32'h5A5A0000;
      do_read(BASE + 24'h5, rd);
      check("rw_new", rd, m_regs[5]);

      // Counter low and high snapshot
      exp = m_cyc[31:0];
      d   = m_cyc[63:32];
      do_read(BASE + 24'h9, rd);
      check("cnt_lo", rd, exp);
      do_read(BASE + 24'hA, rd);
      check("cnt_hi", rd, d);

      // Address change under a held read starts a new read
      do_write(BASE + 24'h1, 32'h11111111);
      m_regs[1] = 32'h11111111;
      do_write(BASE + 24'h2, 32'h22222222);
      m_regs[2] = 32'h22222222;
      bus.lb_addr = BASE + 24'h1;
      bus.lb_read = 1'b1;
      tick();
      bus.lb_addr = BASE + 24'h2;
      tick();
      bus.lb_read = 1'b0;
      tick();
      check("addr_chg_a", bus.lb_rdata, m_regs[1]);
      tick();
      check("addr_chg_b", bus.lb_rdata, m_regs[2]);

      // Randomized register traffic against the model
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 3);
         r  = 3'($urandom_range(0, 7));
         d  = $urandom;
         case (op)
            0: begin
               do_write(BASE + 24'(r), d);
               m_regs[r] = d;
            end
            1: begin
               do_read(BASE + 24'(r), rd);
               check("rand_rd", rd, m_regs[r]);
            end
            2: begin
               do_access(BASE + 24'(r), 1'b1, d, rd);
               check("rand_rw", rd, m_regs[r]);
               m_regs[r] = d;
            end
            default: begin
               do_access(BASE ^ {12'd0, 8'($urandom_range(1, 255)), 1'b0, r},
                         1'b1, d, rd);
               check("rand_miss", rd, 32'd0);
            end
         endcase
      end
      for (int i = 0; i < 8; i++) check("rand_reg_out", reg_out[32*i +: 32], m_regs[i]);

`ifdef LB_RESPONDER_FIFO_EN
      // Fill past full
      for (int i = 1; i <= 9; i++) fifo_op(1'b1, 1'b0, 32'(i));
      do_read(BASE + 24'hB, rd);
      check("st_full", rd, 32'h00010008);
      check("st_full_model", rd, m_status());
      check("fifo_full", {31'd0, fifo_full}, 32'd1);
      for (int i = 0; i < 9; i++) fifo_op(1'b0, 1'b1, 32'd0);
      do_read(BASE + 24'hB, rd);
      check("st_unf", rd, m_status());
      check("st_unf_bit", {31'd0, rd[17]}, 32'd1);

      // Clear, then push+pop while full
      do_write(BASE + 24'hB, 32'd1);
      model_reset_fifo: begin q.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
      do_read(BASE + 24'hB, rd);
      check("st_clear", rd, 32'h80000000);
      for (int i = 0; i < DEPTH; i++) fifo_op(1'b1, 1'b0, $urandom);
      fifo_op(1'b1, 1'b1, 32'hCAFE0001);
      do_read(BASE + 24'hB, rd);
      check("st_pp_full", rd, 32'h00000008);
      do_write(BASE + 24'hB, 32'd1);
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      do_read(BASE + 24'hB, rd);
      check("st_clear2", rd, 32'h80000000);

      // Clear wins over a coinciding push
      fifo_op(1'b1, 1'b0, 32'hAAAA0001);
      bus.lb_addr  = BASE + 24'hB;
      bus.lb_wdata = 32'd1;
      bus.lb_write = 1'b1;
      fifo_push    = 1'b1;
      fifo_din     = 32'hAAAA0002;
      tick();
      bus.lb_write = 1'b0;
      fifo_push    = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      do_read(BASE + 24'hB, rd);
      check("st_clr_push", rd, 32'h80000000);

      // Write of 0 to status is not a clear
      fifo_op(1'b1, 1'b0, 32'hBBBB0001);
      do_write(BASE + 24'hB, 32'd0);
      do_read(BASE + 24'hB, rd);
      check("st_wr0", rd, m_status());

      // Push+pop on empty: pop underflows, push stored
      do_write(BASE + 24'hB, 32'd1);
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      fifo_op(1'b1, 1'b1, 32'h0BAD0001);
      do_read(BASE + 24'hB, rd);
      check("st_pp_empty", rd, 32'h00020001);
      do_write(BASE + 24'hB, 32'd1);
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;

      // Held read pops only once
      for (int i = 0; i < 3; i++) fifo_op(1'b1, 1'b0, 32'h100 + 32'(i));
      exp = q.pop_front();
      bus.lb_addr = BASE + 24'hC;
      bus.lb_read = 1'b1;
      repeat (4) tick();
      bus.lb_read = 1'b0;
      check("held_pop", bus.lb_rdata, exp);
      do_read(BASE + 24'hB, rd);
      check("held_occ", rd, 32'h00000002);

      // Random traffic wraps the pointers
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         fifo_op(op != 1, op != 0, $urandom);
      end
      do_read(BASE + 24'hB, rd);
      check("st_rand", rd, m_status());
      check("full_rand", {31'd0, fifo_full}, {31'd0, q.size() == DEPTH});
`else
      for (int i = 0; i < 4; i++) begin
         fifo_din  = $urandom;
         fifo_push = 1'b1;
         tick();
      end
      fifo_push = 1'b0;
      check("nofifo_full", {31'd0, fifo_full}, 32'd0);
      do_write(BASE + 24'hB, 32'd1);
      do_read(BASE + 24'hB, rd);
      check("nofifo_st", rd, 32'd0);
      do_read(BASE + 24'hC, rd);
      check("nofifo_pop", rd, 32'd0);
`endif

      // Reset one cycle into a read aborts it
      do_read(BASE + 24'h8, rd);
      check("pre_rst", rd, ID);
      bus.lb_addr = BASE + 24'h8;
      bus.lb_read = 1'b1;
      tick();
      bus.lb_read = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         check("rst_abort", bus.lb_rdata, 32'd0);
         tick();
      end
      for (int i = 0; i < 8; i++) check("rst2_reg_out", reg_out[32*i +: 32], 32'd0);
      do_read(BASE + 24'hB, rd);
`ifdef LB_RESPONDER_FIFO_EN
      check("rst2_st", rd, 32'h80000000);
`else
      check("rst2_st", rd, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
